// File: rtl/pc_fetch_if.sv
// Fetch-unit bus: PC adder loop, redirect input, instruction-memory
// request/ack and the valid/ready hand-off to decode.
interface pc_fetch_if;
  logic [31:0] pc_o;
  logic [31:0] seq_pc_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        fault_o;
  logic [31:0] fault_addr_o;

  // Fetch unit side.
  modport master (
    output pc_o, imem_req_o, instr_valid_o, instr_o, instr_pc_o,
           fault_o, fault_addr_o,
    input  seq_pc_i, redirect_valid_i, redirect_target_i,
           imem_ack_i, imem_rdata_i, instr_ready_i
  );

  // Environment side: PC adder, instruction memory, decode, branch unit.
  modport slave (
    input  pc_o, imem_req_o, instr_valid_o, instr_o, instr_pc_o,
           fault_o, fault_addr_o,
    output seq_pc_i, redirect_valid_i, redirect_target_i,
           imem_ack_i, imem_rdata_i, instr_ready_i
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch.
// A request stays on the bus with a stable address until its ack; a
// redirect that arrives while a request is in flight is parked in
// DRAIN and applied when the stale response comes back.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst_n,
  pc_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, VALID, DRAIN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] pending_q, pending_d;
  logic        halt_pending_q, halt_pending_d;

  logic redir_ok, redir_bad;

  assign redir_ok  = bus.redirect_valid_i && (bus.redirect_target_i[1:0] == 2'b00);
  assign redir_bad = bus.redirect_valid_i && (bus.redirect_target_i[1:0] != 2'b00);

  // State register and all architectural flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= '0;
      instr_pc_q     <= '0;
      instr_valid_q  <= 1'b0;
      fault_q        <= 1'b0;
      fault_addr_q   <= '0;
      pending_q      <= '0;
      halt_pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the statement order.
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      instr_valid_q  <= instr_valid_d;
      fault_q        <= fault_d;
      fault_addr_q   <= fault_addr_d;
      pending_q      <= pending_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  // Next-state and next-register logic for the fetch FSM.
  always_comb begin
    // NOTE: every *_d holds its current value by default, so no branch can infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    instr_valid_d  = instr_valid_q;
    fault_d        = fault_q;
    fault_addr_d   = fault_addr_q;
    pending_d      = pending_q;
    halt_pending_d = halt_pending_q;

    if (redir_bad && state_q != HALT) begin
      fault_d       = 1'b1;
      fault_addr_d  = bus.redirect_target_i;
      instr_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir_bad)     state_d = HALT;
        else if (redir_ok) pc_d = bus.redirect_target_i;
      end

      REQ: begin
        if (redir_bad) begin
          if (bus.imem_ack_i) begin
            state_d = HALT;
          end else begin
            halt_pending_d = 1'b1;
            state_d        = DRAIN;
          end
        end else if (redir_ok) begin
          if (bus.imem_ack_i) begin
            pc_d = bus.redirect_target_i;
          end else begin
            pending_d = bus.redirect_target_i;
            state_d   = DRAIN;
          end
        end else if (bus.imem_ack_i) begin
          instr_d       = bus.imem_rdata_i;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = bus.seq_pc_i;
          state_d       = VALID;
        end
      end

      DRAIN: begin
        // A redirect in the same cycle as the ack still counts: latest wins.
        if (redir_bad)     halt_pending_d = 1'b1;
        else if (redir_ok) pending_d = bus.redirect_target_i;
        if (bus.imem_ack_i) begin
          if (halt_pending_d) begin
            state_d = HALT;
          end else begin
            pc_d    = pending_d;
            state_d = REQ;
          end
        end
      end

      VALID: begin
        if (redir_bad) begin
          state_d = HALT;
        end else if (redir_ok) begin
          instr_valid_d = 1'b0;
          pc_d          = bus.redirect_target_i;
          state_d       = REQ;
        end else if (bus.instr_ready_i) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.pc_o          = pc_q;
  assign bus.imem_req_o    = (state_q == REQ) || (state_q == DRAIN);
  assign bus.instr_valid_o = instr_valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_pc_o    = instr_pc_q;
  assign bus.fault_o       = fault_q;
  assign bus.fault_addr_o  = fault_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: behavioural memory, PC adder and decode,
// with a queue of expected (instr, pc) pairs filled at ack time.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_fetch_if ifc ();

  // External PC adder: a = pc_o, b = 4.
  assign ifc.seq_pc_i = ifc.pc_o + 32'd4;

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic idle_inputs();
    ifc.imem_ack_i        = 1'b0;
    ifc.imem_rdata_i      = '0;
    ifc.redirect_valid_i  = 1'b0;
    ifc.redirect_target_i = '0;
    ifc.instr_ready_i     = 1'b0;
  endtask

  // Leaves the bench on the negedge right after release (DUT in IDLE).
  task automatic apply_reset();
    idle_inputs();
    sb.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    checks++; if (ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", ifc.pc_o, RESET_PC); end
    checks++; if (ifc.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ifc.imem_req_o); end
    checks++; if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.instr_valid_o); end
    checks++; if (ifc.instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", ifc.instr_o); end
    checks++; if (ifc.instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", ifc.instr_pc_o); end
    checks++; if (ifc.fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", ifc.fault_o); end
    checks++; if (ifc.fault_addr_o !== 32'h0) begin errors++; $display("FAIL reset_fault_addr: got %h want 0", ifc.fault_addr_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (ifc.imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", ifc.imem_req_o); end
    @(negedge clk);
    checks++; if (ifc.imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", ifc.imem_req_o); end
    checks++; if (ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL first_req_pc: got %h want %h", ifc.pc_o, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    exp_t        e;
    int          got, last_valid;
    apply_reset();
    ifc.instr_ready_i = 1'b1;
    exp_addr   = RESET_PC;
    got        = 0;
    last_valid = -1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      ifc.imem_ack_i = 1'b0;
      if (ifc.instr_valid_o === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL seq_unexpected_valid: got valid with pc %h, want none", ifc.instr_pc_o);
        end else begin
          e = sb.pop_front();
          if (ifc.instr_pc_o !== e.pc) begin errors++; $display("FAIL seq_instr_pc: got %h want %h", ifc.instr_pc_o, e.pc); end
          checks++; if (ifc.instr_o !== e.instr) begin errors++; $display("FAIL seq_instr: got %h want %h", ifc.instr_o, e.instr); end
        end
        if (last_valid >= 0) begin
          checks++; if (cyc - last_valid != 2) begin errors++; $display("FAIL seq_interval: got %0d want 2", cyc - last_valid); end
        end
        last_valid = cyc;
        got++;
      end
      if (ifc.imem_req_o === 1'b1) begin
        checks++; if (ifc.pc_o !== exp_addr) begin errors++; $display("FAIL seq_req_addr: got %h want %h", ifc.pc_o, exp_addr); end
        ifc.imem_ack_i   = 1'b1;
        ifc.imem_rdata_i = mem_word(ifc.pc_o);
        sb.push_back('{instr: mem_word(exp_addr), pc: exp_addr});
        exp_addr += 32'd4;
      end
      @(negedge clk);
    end
    checks++; if (got != 3) begin errors++; $display("FAIL seq_count: got %0d want 3", got); end
    idle_inputs();
  endtask

  task automatic test_stall();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 10 && ifc.imem_req_o !== 1'b1; i++) @(negedge clk);
    checks++; if (ifc.imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_req_wait: got %b want 1", ifc.imem_req_o); end
    ifc.imem_ack_i   = 1'b1;
    ifc.imem_rdata_i = mem_word(ifc.pc_o);
    sb.push_back('{instr: mem_word(RESET_PC), pc: RESET_PC});
    @(negedge clk);
    ifc.imem_ack_i = 1'b0;
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      checks++; if (ifc.instr_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, ifc.instr_valid_o); end
      checks++; if (ifc.instr_o !== e.instr) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", k, ifc.instr_o, e.instr); end
      checks++; if (ifc.instr_pc_o !== e.pc) begin errors++; $display("FAIL stall_instr_pc[%0d]: got %h want %h", k, ifc.instr_pc_o, e.pc); end
      checks++; if (ifc.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", k, ifc.imem_req_o); end
      @(negedge clk);
    end
    ifc.instr_ready_i = 1'b1;
    e = sb.pop_front();
    checks++; if (ifc.instr_pc_o !== e.pc || ifc.instr_valid_o !== 1'b1) begin errors++; $display("FAIL stall_accept: got pc %h valid %b want pc %h valid 1", ifc.instr_pc_o, ifc.instr_valid_o, e.pc); end
    @(negedge clk);
    ifc.instr_ready_i = 1'b0;
    checks++; if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid_drop: got %b want 0", ifc.instr_valid_o); end
    checks++; if (ifc.imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_next_req: got %b want 1", ifc.imem_req_o); end
    checks++; if (ifc.pc_o !== RESET_PC + 32'd4) begin errors++; $display("FAIL stall_next_addr: got %h want %h", ifc.pc_o, RESET_PC + 32'd4); end
    idle_inputs();
  endtask

  task automatic test_drain_redirect();
    apply_reset();
    ifc.instr_ready_i = 1'b1;
    for (int i = 0; i < 10 && ifc.imem_req_o !== 1'b1; i++) @(negedge clk);
    checks++; if (ifc.imem_req_o !== 1'b1) begin errors++; $display("FAIL drain_req_wait: got %b want 1", ifc.imem_req_o); end
    ifc.redirect_valid_i  = 1'b1;
    ifc.redirect_target_i = 32'h0040_0100;
    @(negedge clk);
    checks++; if (ifc.imem_req_o !== 1'b1 || ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL drain_hold1: got req %b pc %h want req 1 pc %h", ifc.imem_req_o, ifc.pc_o, RESET_PC); end
    ifc.redirect_target_i = 32'h0040_0200;
    @(negedge clk);
    ifc.redirect_valid_i = 1'b0;
    checks++; if (ifc.imem_req_o !== 1'b1 || ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL drain_hold2: got req %b pc %h want req 1 pc %h", ifc.imem_req_o, ifc.pc_o, RESET_PC); end
    ifc.imem_ack_i   = 1'b1;
    ifc.imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    ifc.imem_ack_i = 1'b0;
    checks++; if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL drain_no_valid: got %b want 0", ifc.instr_valid_o); end
    checks++; if (ifc.imem_req_o !== 1'b1) begin errors++; $display("FAIL drain_new_req: got %b want 1", ifc.imem_req_o); end
    checks++; if (ifc.pc_o !== 32'h0040_0200) begin errors++; $display("FAIL drain_latest_wins: got %h want 00400200", ifc.pc_o); end
  endtask

  // Continues from test_drain_redirect: DUT is in REQ at 0x00400200.
  task automatic test_redirect_on_ack();
    ifc.instr_ready_i     = 1'b0;
    ifc.imem_ack_i        = 1'b1;
    ifc.imem_rdata_i      = 32'hBAD0_0001;
    ifc.redirect_valid_i  = 1'b1;
    ifc.redirect_target_i = 32'h0040_0040;
    @(negedge clk);
    ifc.imem_ack_i       = 1'b0;
    ifc.redirect_valid_i = 1'b0;
    checks++; if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL ack_redir_valid: got %b want 0", ifc.instr_valid_o); end
    checks++; if (ifc.imem_req_o !== 1'b1 || ifc.pc_o !== 32'h0040_0040) begin errors++; $display("FAIL ack_redir_addr: got req %b pc %h want req 1 pc 00400040", ifc.imem_req_o, ifc.pc_o); end
    ifc.imem_ack_i   = 1'b1;
    ifc.imem_rdata_i = mem_word(ifc.pc_o);
    @(negedge clk);
    ifc.imem_ack_i = 1'b0;
    checks++; if (ifc.instr_valid_o !== 1'b1 || ifc.instr_pc_o !== 32'h0040_0040) begin errors++; $display("FAIL ack_redir_fetch: got valid %b pc %h want valid 1 pc 00400040", ifc.instr_valid_o, ifc.instr_pc_o); end
    checks++; if (ifc.instr_o !== mem_word(32'h0040_0040)) begin errors++; $display("FAIL ack_redir_instr: got %h want %h", ifc.instr_o, mem_word(32'h0040_0040)); end
    ifc.redirect_valid_i  = 1'b1;
    ifc.redirect_target_i = 32'h0040_0080;
    @(negedge clk);
    ifc.redirect_valid_i = 1'b0;
    checks++; if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL valid_flush: got %b want 0", ifc.instr_valid_o); end
    checks++; if (ifc.imem_req_o !== 1'b1 || ifc.pc_o !== 32'h0040_0080) begin errors++; $display("FAIL valid_redir_addr: got req %b pc %h want req 1 pc 00400080", ifc.imem_req_o, ifc.pc_o); end
    idle_inputs();
  endtask

  task automatic test_fault();
    apply_reset();
    ifc.instr_ready_i = 1'b1;
    for (int i = 0; i < 10 && ifc.imem_req_o !== 1'b1; i++) @(negedge clk);
    checks++; if (ifc.imem_req_o !== 1'b1) begin errors++; $display("FAIL fault_req_wait: got %b want 1", ifc.imem_req_o); end
    ifc.redirect_valid_i  = 1'b1;
    ifc.redirect_target_i = 32'h0040_0102;
    @(negedge clk);
    ifc.redirect_valid_i = 1'b0;
    checks++; if (ifc.fault_o !== 1'b1) begin errors++; $display("FAIL fault_set: got %b want 1", ifc.fault_o); end
    checks++; if (ifc.fault_addr_o !== 32'h0040_0102) begin errors++; $display("FAIL fault_addr: got %h want 00400102", ifc.fault_addr_o); end
    checks++; if (ifc.imem_req_o !== 1'b1 || ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL fault_hold1: got req %b pc %h want req 1 pc %h", ifc.imem_req_o, ifc.pc_o, RESET_PC); end
    @(negedge clk);
    checks++; if (ifc.imem_req_o !== 1'b1 || ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL fault_hold2: got req %b pc %h want req 1 pc %h", ifc.imem_req_o, ifc.pc_o, RESET_PC); end
    ifc.imem_ack_i   = 1'b1;
    ifc.imem_rdata_i = 32'h0BAD_0BAD;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (ifc.imem_req_o !== 1'b0 || ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL halt_quiet[%0d]: got req %b valid %b want 0 0", k, ifc.imem_req_o, ifc.instr_valid_o); end
      checks++; if (ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL halt_pc[%0d]: got %h want %h", k, ifc.pc_o, RESET_PC); end
      checks++; if (ifc.fault_o !== 1'b1 || ifc.fault_addr_o !== 32'h0040_0102) begin errors++; $display("FAIL halt_fault_hold[%0d]: got %b %h want 1 00400102", k, ifc.fault_o, ifc.fault_addr_o); end
      ifc.imem_ack_i        = 1'b1;
      ifc.redirect_valid_i  = 1'b1;
      ifc.redirect_target_i = 32'h0040_0300;
      @(negedge clk);
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.fault_o !== 1'b0 || ifc.fault_addr_o !== 32'h0) begin errors++; $display("FAIL rst_clears_fault: got %b %h want 0 0", ifc.fault_o, ifc.fault_addr_o); end
    checks++; if (ifc.pc_o !== RESET_PC || ifc.imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_pc: got pc %h req %b want %h 0", ifc.pc_o, ifc.imem_req_o, RESET_PC); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifc.imem_req_o !== 1'b1 || ifc.pc_o !== RESET_PC) begin errors++; $display("FAIL restart: got req %b pc %h want 1 %h", ifc.imem_req_o, ifc.pc_o, RESET_PC); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_drain_redirect();
    test_redirect_on_ack();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
